// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the single-lane SPI flash read controller.
package spi_flash_pkg;

  localparam int         ADDR_W    = 24;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_PWRUP = 8'hAB;

  typedef enum logic [3:0] {
    ST_PWRUP_GAP,
    ST_PWRUP_CMD,
    ST_PWRUP_WAIT,
    ST_IDLE,
    ST_GAP,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } state_e;

endpackage

// File: rtl/spi_byte_engine.sv
// Shifts one byte out/in in SPI mode 0, MSB first; 2*CLK_DIV clk cycles per bit.
// done_o fires in the cycle of the final falling edge so a new start can follow with no gap.
module spi_byte_engine #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] tx_byte_i,
  input  logic       miso_i,
  output logic       sclk_o,
  output logic       mosi_o,
  output logic [7:0] rx_byte_o,
  output logic       busy_o,
  output logic       done_o
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_q;
  logic [2:0]    bit_q;
  logic          busy_q;
  logic          sclk_q;
  logic          mosi_q;
  logic [6:0]    sh_q;
  logic [7:0]    rx_q;
  logic          half_end;

  assign half_end  = (div_q == DW'(CLK_DIV - 1));
  assign done_o    = busy_q && half_end && sclk_q && (bit_q == 3'd7);
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;
  assign rx_byte_o = rx_q;
  assign busy_o    = busy_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q  <= '0;
      bit_q  <= '0;
      busy_q <= 1'b0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      sh_q   <= '0;
      rx_q   <= '0;
    end else if (start_i) begin
      div_q  <= '0;
      bit_q  <= '0;
      busy_q <= 1'b1;
      sclk_q <= 1'b0;
      mosi_q <= tx_byte_i[7];
      sh_q   <= tx_byte_i[6:0];
    end else if (busy_q) begin
      if (half_end) begin
        div_q <= '0;
        if (!sclk_q) begin
          sclk_q <= 1'b1;
          rx_q   <= {rx_q[6:0], miso_i};
        end else begin
          sclk_q <= 1'b0;
          if (bit_q == 3'd7) begin
            busy_q <= 1'b0;
          end else begin
            bit_q  <= bit_q + 3'd1;
            mosi_q <= sh_q[6];
            sh_q   <= {sh_q[5:0], 1'b0};
          end
        end
      end else begin
        div_q <= div_q + DW'(1);
      end
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// Word read controller for a serial flash: wakes the part with 0xAB, then serves 32-bit reads
// with 0x03 + address, continuing sequential reads without a new command while csb stays low.
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int CSB_GAP    = 4,
  parameter int PWRUP_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [ADDR_W-1:0] addr,
  output logic              ready,
  output logic [31:0]       rdata,
  output logic              flash_csb,
  output logic              flash_clk,
  output logic              flash_mosi,
  input  logic              flash_miso,
  output logic              flash_wpn,
  output logic              flash_holdn
);
  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [1:0]        byte_q, byte_d;
  logic              csb_q, csb_d;
  logic              cont_q, cont_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [23:0]       word_q, word_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              eng_start, eng_busy, eng_done;
  logic [7:0]        eng_tx, eng_rx;

  spi_byte_engine #(.CLK_DIV(CLK_DIV)) u_engine (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (eng_start),
    .tx_byte_i (eng_tx),
    .miso_i    (flash_miso),
    .sclk_o    (flash_clk),
    .mosi_o    (flash_mosi),
    .rx_byte_o (eng_rx),
    .busy_o    (eng_busy),
    .done_o    (eng_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_PWRUP_GAP;
      cnt_q       <= '0;
      byte_q      <= '0;
      csb_q       <= 1'b1;
      cont_q      <= 1'b0;
      addr_q      <= '0;
      next_addr_q <= '0;
      word_q      <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      byte_q      <= byte_d;
      csb_q       <= csb_d;
      cont_q      <= cont_d;
      addr_q      <= addr_d;
      next_addr_q <= next_addr_d;
      word_q      <= word_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    byte_d      = byte_q;
    csb_d       = csb_q;
    cont_d      = cont_q;
    addr_d      = addr_q;
    next_addr_d = next_addr_q;
    word_d      = word_q;
    rdata_d     = rdata_q;
    eng_start   = 1'b0;
    eng_tx      = 8'h00;
    unique case (state_q)
      ST_PWRUP_GAP: begin
        csb_d = 1'b1;
        if (cnt_q == 16'(CSB_GAP - 1)) begin
          state_d = ST_PWRUP_CMD;
          csb_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_PWRUP_CMD: begin
        if (eng_done) begin
          csb_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_PWRUP_WAIT;
        end else if (!eng_busy) begin
          eng_start = 1'b1;
          eng_tx    = CMD_PWRUP;
        end
      end
      ST_PWRUP_WAIT: begin
        if (cnt_q == 16'(PWRUP_WAIT - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_IDLE: begin
        if (valid) begin
          addr_d = addr;
          byte_d = '0;
          cnt_d  = '0;
          if (cont_q && (addr == next_addr_q)) begin
            // Flash is still streaming from next_addr: just keep clocking data.
            state_d   = ST_DATA;
            eng_start = 1'b1;
          end else begin
            csb_d   = 1'b1;
            cont_d  = 1'b0;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (cnt_q == 16'(CSB_GAP - 1)) begin
          state_d = ST_CMD;
          csb_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_CMD: begin
        if (eng_done) begin
          eng_start = 1'b1;
          eng_tx    = addr_q[23:16];
          byte_d    = '0;
          state_d   = ST_ADDR;
        end else if (!eng_busy) begin
          eng_start = 1'b1;
          eng_tx    = CMD_READ;
        end
      end
      ST_ADDR: begin
        if (eng_done) begin
          eng_start = 1'b1;
          if (byte_q == 2'd2) begin
            byte_d  = '0;
            state_d = ST_DATA;
          end else begin
            eng_tx = (byte_q == 2'd0) ? addr_q[15:8] : addr_q[7:0];
            byte_d = byte_q + 2'd1;
          end
        end
      end
      ST_DATA: begin
        if (eng_done) begin
          if (byte_q == 2'd3) begin
            rdata_d = {eng_rx, word_q};
            state_d = ST_DONE;
          end else begin
            word_d    = {eng_rx, word_q[23:8]};
            eng_start = 1'b1;
            byte_d    = byte_q + 2'd1;
          end
        end
      end
      ST_DONE: begin
        next_addr_d = addr_q + ADDR_W'(4);
        cont_d      = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_PWRUP_GAP;
    endcase
  end

  assign ready       = (state_q == ST_DONE);
  assign rdata       = rdata_q;
  assign flash_csb   = csb_q;
  assign flash_wpn   = 1'b1;
  assign flash_holdn = 1'b1;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench: three readers (CLK_DIV 2, 1, 5) each talking to a behavioural flash model.
module tb_spi_flash_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid [3];
  logic [23:0] addr  [3];
  wire         ready [3];
  wire  [31:0] rdata [3];
  wire         csb   [3];
  wire         sclk  [3];
  wire         mosi  [3];
  wire         wpn   [3];
  wire         holdn [3];
  wire  [31:0] ph        [3];
  wire  [31:0] rises_w   [3];
  wire  [31:0] last_hi_w [3];
  wire  [31:0] rdy_cnt_w [3];
  wire  [31:0] dbits     [3];

  logic [7:0]  mem [logic [23:0]];
  logic [31:0] exp_q [3][$];
  logic [7:0]  exp_wire [$];
  int          wire_rd = 0;
  int          n_assert = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_rd(input logic [23:0] a);
    return mem.exists(a) ? mem[a] : 8'hFF;
  endfunction

  function automatic logic [31:0] word_at(input logic [23:0] a);
    return {mem_rd(a + 24'd3), mem_rd(a + 24'd2), mem_rd(a + 24'd1), mem_rd(a)};
  endfunction

  function automatic int cd(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 5);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : fl
    localparam int CD = (g == 0) ? 2 : ((g == 1) ? 1 : 5);
    logic        miso = 1'b0;
    logic [7:0]  sr = 8'h00;
    logic [7:0]  cmd = 8'h00;
    logic [7:0]  b = 8'h00;
    logic [23:0] ra = 24'h0;
    logic        dmode = 1'b0;
    int          nbit = 0, tbyte = 0, dcount = 0;
    logic [7:0]  obs [$];
    int          hi_run = 0, lo_run = 0, hi_min = 99, hi_max = 0, lo_min = 99, lo_max = 0;
    logic        prev = 1'b0, lo_vld = 1'b0;
    int          rises = 0, hi_cnt = 0, last_hi = 0, rdy_cnt = 0;

    spi_flash_reader #(.CLK_DIV(CD), .CSB_GAP(4), .PWRUP_WAIT(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .valid       (valid[g]),
      .addr        (addr[g]),
      .ready       (ready[g]),
      .rdata       (rdata[g]),
      .flash_csb   (csb[g]),
      .flash_clk   (sclk[g]),
      .flash_mosi  (mosi[g]),
      .flash_miso  (miso),
      .flash_wpn   (wpn[g]),
      .flash_holdn (holdn[g])
    );

    // Flash side: command/address bytes sampled on rising sclk.
    always @(posedge sclk[g] or posedge csb[g]) begin
      if (csb[g]) begin
        nbit  = 0;
        tbyte = 0;
        dmode = 1'b0;
      end else begin
        sr   = {sr[6:0], mosi[g]};
        nbit = nbit + 1;
        if (nbit == 8) begin
          nbit = 0;
          if (!dmode) begin
            if (tbyte == 0) cmd = sr;
            if (tbyte == 0 || (cmd == 8'h03 && tbyte <= 3)) obs.push_back(sr);
            if (tbyte >= 1 && tbyte <= 3) ra = {ra[15:0], sr};
            if (cmd == 8'h03 && tbyte == 3) dmode = 1'b1;
          end
          tbyte = tbyte + 1;
        end
      end
    end

    always @(negedge sclk[g]) begin
      if (!csb[g] && dmode) begin
        b      = mem_rd(ra + 24'(dcount / 8));
        miso   = b[3'(7 - dcount % 8)];
        dcount = dcount + 1;
      end else begin
        dcount = 0;
      end
    end

    always @(posedge csb[g]) rises = rises + 1;

    always @(negedge clk) begin
      if (ready[g] === 1'b1) rdy_cnt = rdy_cnt + 1;
      if (csb[g] === 1'b1) begin
        hi_cnt = hi_cnt + 1;
        lo_vld = 1'b0;
      end else begin
        if (hi_cnt > 0) last_hi = hi_cnt;
        hi_cnt = 0;
        if (sclk[g] === 1'b1) begin
          if (!prev && lo_vld) begin
            if (lo_run < lo_min) lo_min = lo_run;
            if (lo_run > lo_max) lo_max = lo_run;
          end
          hi_run = prev ? hi_run + 1 : 1;
        end else if (prev) begin
          if (hi_run < hi_min) hi_min = hi_run;
          if (hi_run > hi_max) hi_max = hi_run;
          lo_run = 1;
          lo_vld = 1'b1;
        end else begin
          lo_run = lo_run + 1;
        end
      end
      prev = (sclk[g] === 1'b1);
    end

    assign ph[g]        = {hi_min[7:0], hi_max[7:0], lo_min[7:0], lo_max[7:0]};
    assign rises_w[g]   = rises;
    assign last_hi_w[g] = last_hi;
    assign rdy_cnt_w[g] = rdy_cnt;
    assign dbits[g]     = dmode ? dcount : 0;
  end

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  task automatic check_wire();
    logic [15:0] o;
    logic [7:0]  e;
    while (exp_wire.size() > 0) begin
      e = exp_wire.pop_front();
      o = (wire_rd < fl[0].obs.size()) ? {8'h00, fl[0].obs[wire_rd]} : 16'hFFFF;
      wire_rd++;
      check("wire_byte", 32'(o), 32'(e));
    end
  endtask

  // exp_lat == 0 skips the latency check (request raised during power-up).
  task automatic rd(input int g, input logic [23:0] a, input int exp_lat, input bit fresh);
    int n;
    exp_q[g].push_back(word_at(a));
    if (fresh && g == 0) begin
      exp_wire.push_back(8'h03);
      exp_wire.push_back(a[23:16]);
      exp_wire.push_back(a[15:8]);
      exp_wire.push_back(a[7:0]);
    end
    valid[g] = 1'b1;
    addr[g]  = a;
    n = 0;
    while (ready[g] !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("ready_seen", 32'(n < 5000), 32'd1);
    if (exp_lat > 0) check("latency", 32'(n), 32'(exp_lat));
    check("rdata", rdata[g], exp_q[g].pop_front());
    valid[g] = 1'b0;
    @(negedge clk);
    check("ready_single_pulse", 32'(ready[g]), 32'd0);
  endtask

  initial begin
    int r0;
    int n;
    for (int i = 0; i < 8; i++) mem[24'h000100 + 24'(i)] = 8'(i * 8'h11);
    mem[24'hFFFFFC] = 8'hDE; mem[24'hFFFFFD] = 8'hAD;
    mem[24'hFFFFFE] = 8'hBE; mem[24'hFFFFFF] = 8'hEF;
    mem[24'h000000] = 8'h01; mem[24'h000001] = 8'h02;
    mem[24'h000002] = 8'h03; mem[24'h000003] = 8'h04;
    for (int g = 0; g < 3; g++) begin
      valid[g] = 1'b0;
      addr[g]  = 24'h0;
    end

    rst = 1'b1;
    repeat (10) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check("rst_csb",   32'(csb[g]),   32'd1);
      check("rst_sclk",  32'(sclk[g]),  32'd0);
      check("rst_mosi",  32'(mosi[g]),  32'd0);
      check("rst_ready", 32'(ready[g]), 32'd0);
      check("rst_rdata", rdata[g],      32'd0);
      check("rst_wpn",   32'(wpn[g]),   32'd1);
      check("rst_holdn", 32'(holdn[g]), 32'd1);
    end

    // Power-up then read; requests are raised while the wake-up is still in progress.
    exp_wire.push_back(8'hAB);
    rst = 1'b0;
    for (int g = 0; g < 3; g++) rd(g, 24'h000100, 0, 1'b1);
    check_wire();
    for (int g = 0; g < 3; g++)
      check("sclk_phases", ph[g], {4{8'(cd(g))}});

    // Sequential continuation on every divider.
    for (int g = 0; g < 3; g++) begin
      r0 = int'(rises_w[g]);
      rd(g, 24'h000104, 64 * cd(g) + 1, 1'b0);
      check("cont_csb_low", rises_w[g], 32'(r0));
    end
    check("cont_no_cmd", 32'(fl[0].obs.size()), 32'(wire_rd));

    // Non-sequential read forces a fresh command.
    rd(0, 24'h000101, 4 + 1 + 128 * 2 + 1, 1'b1);
    check("csb_gap", 32'(last_hi_w[0] >= 32'd4), 32'd1);
    check_wire();

    // Address wrap.
    rd(0, 24'hFFFFFC, 4 + 1 + 128 * 2 + 1, 1'b1);
    rd(0, 24'h000000, 64 * 2 + 1, 1'b0);
    check_wire();

    // Reset part-way through the data phase.
    r0 = int'(rdy_cnt_w[0]);
    exp_wire.push_back(8'h03);
    exp_wire.push_back(8'h00);
    exp_wire.push_back(8'h01);
    exp_wire.push_back(8'h00);
    valid[0] = 1'b1;
    addr[0]  = 24'h000100;
    n = 0;
    while (csb[0] !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    while (dbits[0] < 32'd10 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("mid_data_reached", 32'(n < 5000), 32'd1);
    rst      = 1'b1;
    valid[0] = 1'b0;
    @(negedge clk);
    check("abort_csb",   32'(csb[0]),   32'd1);
    check("abort_sclk",  32'(sclk[0]),  32'd0);
    check("abort_ready", 32'(ready[0]), 32'd0);
    repeat (2) @(negedge clk);
    exp_wire.push_back(8'hAB);
    rst = 1'b0;
    rd(0, 24'h000100, 0, 1'b1);
    check("abort_no_ready", rdy_cnt_w[0], 32'(r0 + 1));
    check_wire();
    check("wire_extra", 32'(fl[0].obs.size()), 32'(wire_rd));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_flash_reader.md
Name: spi_flash_reader

Overview:
Synthesizable single-lane SPI flash read controller. It sits between the SoC instruction/data bus and the external serial flash pins, and is the master that drives the flash simulation model in benches. It converts 32-bit word read requests into flash transactions:
- a one-time 0xAB release-power-down after reset;
- 0x03 READ with a 24-bit address;
- sequential continuation without a new command while chip-select stays low.

Parameters:
- CLK_DIV, 2, flash_clk half-period in clk cycles (>=1); one SPI bit = 2*CLK_DIV cycles.
- CSB_GAP, 4, minimum clk cycles flash_csb is held high between transactions.
- PWRUP_WAIT, 16, clk cycles after the 0xAB transaction before the first read command.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- valid  in  1  read request; held until ready
- addr  in  24  byte address of the word; stable while valid
- ready  out  1  one-cycle pulse, rdata valid this cycle
- rdata  out  32  little-endian word: rdata[7:0] = byte at addr
- flash_csb  out  1  chip select, active low
- flash_clk  out  1  SPI clock, mode 0, idles low
- flash_mosi  out  1  io0
- flash_miso  in  1  io1
- flash_wpn  out  1  io2, constant 1
- flash_holdn  out  1  io3, constant 1

Behaviour:
- One clock (clk); reset (rst) is synchronous and active-high.
- Reset values: flash_csb=1, flash_clk=0, flash_mosi=0, ready=0, rdata=0, flash_wpn=1, flash_holdn=1, cont_valid=0.
- Bit timing:
  - flash_mosi changes only on the clk edge where flash_clk goes 1->0, or at the start of the byte with flash_clk low.
  - flash_miso is registered on the clk edge where flash_clk goes 0->1.
  - Bits are MSB first.
- FSM states:
  - PWRUP_GAP: csb high for CSB_GAP cycles.
  - PWRUP_CMD: shift 0xAB, then csb high.
  - PWRUP_WAIT: PWRUP_WAIT cycles.
  - IDLE.
  - GAP: csb high for CSB_GAP cycles.
  - CMD: 0x03.
  - ADDR: 3 bytes, addr[23:16] first.
  - DATA: 4 bytes, shifted into rdata LSB byte first.
  - DONE: ready=1 for one cycle.
- After DONE go to IDLE with csb still low and flash_clk low. Record next_addr = addr+4 (mod 2^24) and set cont_valid=1.
- IDLE transitions:
  - valid && cont_valid && addr==next_addr -> DATA directly, no command or address bytes.
  - valid otherwise -> raise csb, clear cont_valid, GAP -> CMD -> ADDR -> DATA.
  - Requests arriving during power-up are held, not dropped; valid is not sampled until IDLE.
- Latency from valid in IDLE to ready:
  - fresh read: (CSB_GAP + 1) + 64*2*CLK_DIV + 1 cycles;
  - continuation: 32*2*CLK_DIV + 1 cycles.
- ready is never asserted while valid is low. rdata holds its value until the next DONE.
- Address wrap: 0xFFFFFC's next_addr is 0x000000, continuation allowed, matching flash internal wrap.
- Unaligned addr is legal: 4 consecutive bytes are returned.
- Reset mid-transfer: on the next cycle csb=1 and clk=0, the partial word is discarded, no ready pulse, and power-up restarts (0xAB resent).
- valid deasserted mid-transaction is a protocol violation; the transaction completes and ready pulses anyway.

Decomposition:
- Package spi_flash_pkg holds:
  - state enum;
  - constants CMD_READ=8'h03, CMD_PWRUP=8'hAB;
  - ADDR_W=24.
- Sub-module spi_byte_engine (parameter CLK_DIV):
  - start, tx_byte[7:0], miso -> sclk, mosi, rx_byte[7:0], done pulse;
  - owns the bit counter and half-period divider.
- The top owns the FSM, csb, byte counter, next_addr and rdata assembly.

Test Plan:
- Power-up then read:
  - Stimulus: flash memory[0x000100..0x000107]=00 11 22 33 44 55 66 77; rst 10 cycles; valid addr=0x000100.
  - Response: wire bytes AB (csb high after), then 03 00 01 00; rdata=0x33221100; single ready pulse.
- Sequential continuation:
  - Stimulus: after the read above, valid addr=0x000104.
  - Response: csb stays low, no command byte, rdata=0x77665544, latency 32*2*CLK_DIV+1=129 cycles with CLK_DIV=2.
- Non-sequential:
  - Stimulus: next read addr=0x000101.
  - Response: csb high for >=CSB_GAP cycles, new 03 00 01 01, rdata=0x44332211.
- Wrap:
  - Stimulus: memory[0xFFFFFC..]=DE AD BE EF, memory[0]=01 02 03 04; read 0xFFFFFC then 0x000000.
  - Response: 0xEFBEADDE, then 0x04030201 via continuation.
- Reset mid-DATA:
  - Stimulus: assert rst after 10 data bits.
  - Response: next cycle csb=1, clk=0, no ready; re-read 0x000100 after reset returns 0x33221100 with 0xAB resent.
- Divider sweep:
  - Stimulus: CLK_DIV=1 and 5, repeat the first scenario.
  - Response: same data; flash_clk high/low phases exactly CLK_DIV cycles each.
